uart_frame_sequencer: RTL and testbench

Parametrised frame-level bit sequencer for the UART transmit and receive datapaths. It generalises the fixed-count bit counter: each frame is sequenced through start, data, optional parity and one or two stop bits. Frame length is programmable per frame. It sits between the baud-tick generator, whose `btu` is a one-cycle bit-time-up tick, and the shift register. It tells the shift register when to shift and when the frame is complete.

---
 rtl/uart_frame_sequencer_if.sv | 30 +++
 rtl/uart_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sequencer_if.sv
// Handshake and status bundle between the frame sequencer and its neighbours
// (baud-tick generator, shift register, configuration source).
interface uart_frame_sequencer_if #(
    parameter int IW = 4
);
    logic          start;
    logic          btu;
    logic          abort;
    logic [IW-1:0] data_bits;
    logic          parity_en;
    logic          stop2;
    logic [2:0]    state;
    logic          busy;
    logic [IW-1:0] bit_idx;
    logic          shift;
    logic          done;
    logic          cfg_err;

    // Controller side: issues requests and configuration, observes progress.
    modport master (
        output start, btu, abort, data_bits, parity_en, stop2,
        input  state, busy, bit_idx, shift, done, cfg_err
    );

    // Sequencer side.
    modport slave (
        input  start, btu, abort, data_bits, parity_en, stop2,
        output state, busy, bit_idx, shift, done, cfg_err
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Frame-level UART bit sequencer: walks start, data, optional parity and one
// or two stop bits, advancing one bit per baud tick. Frame configuration is
// latched when a start is accepted so mid-frame input changes are harmless.
module uart_frame_sequencer #(
    parameter int MIN_BITS = 5,
    parameter int MAX_BITS = 9,
    parameter int IW       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [IW-1:0] MIN_V = IW'(MIN_BITS);
    localparam logic [IW-1:0] MAX_V = IW'(MAX_BITS);
    localparam logic [IW-1:0] ONE   = IW'(1);

    state_t        state_reg,   state_next;
    logic [IW-1:0] bit_idx_reg, bit_idx_next;
    logic          done_reg,    done_next;
    logic          cfg_err_reg, cfg_err_next;
    logic [IW-1:0] bits_reg,    bits_next;
    logic          parity_reg,  parity_next;
    logic          stop2_reg,   stop2_next;

    logic cfg_ok;
    logic last_data;

    assign cfg_ok    = (bus.data_bits >= MIN_V) && (bus.data_bits <= MAX_V);
    assign last_data = (bit_idx_reg == bits_reg - ONE);

    // State, bit index, pulse outputs and latched frame configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            bit_idx_reg <= '0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            bits_reg    <= '0;
            parity_reg  <= 1'b0;
            stop2_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            done_reg    <= done_next;
            cfg_err_reg <= cfg_err_next;
            bits_reg    <= bits_next;
            parity_reg  <= parity_next;
            stop2_reg   <= stop2_next;
        end
    end

    // Next-state logic; abort outranks the bit tick, and a tick arriving with
    // an accepted start is not counted because only IDLE is evaluated then.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        done_next    = 1'b0;
        cfg_err_next = 1'b0;
        bits_next    = bits_reg;
        parity_next  = parity_reg;
        stop2_next   = stop2_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (cfg_ok) begin
                        bits_next    = bus.data_bits;
                        parity_next  = bus.parity_en;
                        stop2_next   = bus.stop2;
                        state_next   = S_START;
                        bit_idx_next = '0;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            S_START: begin
                if (bus.abort) begin
                    state_next   = S_IDLE;
                    bit_idx_next = '0;
                end else if (bus.btu) begin
                    state_next   = S_DATA;
                    bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (bus.abort) begin
                    state_next   = S_IDLE;
                    bit_idx_next = '0;
                end else if (bus.btu) begin
                    if (!last_data) begin
                        bit_idx_next = bit_idx_reg + ONE;
                    end else begin
                        bit_idx_next = '0;
                        state_next   = parity_reg ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bus.abort) begin
                    state_next   = S_IDLE;
                    bit_idx_next = '0;
                end else if (bus.btu) begin
                    state_next   = S_STOP;
                    bit_idx_next = '0;
                end
            end
            S_STOP: begin
                if (bus.abort) begin
                    state_next   = S_IDLE;
                    bit_idx_next = '0;
                end else if (bus.btu) begin
                    if (stop2_reg && (bit_idx_reg == '0)) begin
                        bit_idx_next = ONE;
                    end else begin
                        state_next   = S_IDLE;
                        bit_idx_next = '0;
                        done_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = S_IDLE;
                bit_idx_next = '0;
            end
        endcase
    end

    assign bus.state   = state_reg;
    assign bus.busy    = (state_reg != S_IDLE);
    assign bus.bit_idx = bit_idx_reg;
    assign bus.shift   = (state_reg == S_DATA) && bus.btu;
    assign bus.done    = done_reg;
    assign bus.cfg_err = cfg_err_reg;
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Self-checking bench for uart_frame_sequencer: a frame-list model predicts
// every output each cycle, and directed scenarios pin counts by hand.
module tb_uart_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_frame_sequencer_if #(.IW(4)) bus ();

    uart_frame_sequencer #(.MIN_BITS(5), .MAX_BITS(9), .IW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- model: a frame is a list of (state, bit_idx) slots ----
    int f_st [0:15];
    int f_ix [0:15];
    int f_len;
    int m_pos;
    bit m_active;
    bit m_done;
    bit m_cfg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_done   <= 1'b0;
            m_cfg    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_cfg  <= 1'b0;
            if (!m_active) begin
                if (bus.start && !bus.abort) begin
                    if (bus.data_bits >= 5 && bus.data_bits <= 9) begin
                        int db;
                        int par;
                        db  = int'(bus.data_bits);
                        par = bus.parity_en ? 1 : 0;
                        m_active <= 1'b1;
                        m_pos    <= 0;
                        f_len    <= 2 + db + par + (bus.stop2 ? 1 : 0);
                        for (int k = 0; k < 16; k++) begin
                            if (k == 0) begin
                                f_st[k] <= 1; f_ix[k] <= 0;
                            end else if (k <= db) begin
                                f_st[k] <= 2; f_ix[k] <= k - 1;
                            end else if (par == 1 && k == db + 1) begin
                                f_st[k] <= 3; f_ix[k] <= 0;
                            end else begin
                                f_st[k] <= 4; f_ix[k] <= k - (db + 1 + par);
                            end
                        end
                    end else begin
                        m_cfg <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                m_active <= 1'b0;
            end else if (bus.btu) begin
                if (m_pos + 1 == f_len) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    int exp_state;
    int exp_idx;
    always_comb begin
        exp_state = 0;
        exp_idx   = 0;
        if (m_active) begin
            exp_state = f_st[m_pos];
            exp_idx   = f_ix[m_pos];
        end
    end

    // ---------------- per-cycle compare and event counters -----------------
    int shift_total = 0;
    int done_total  = 0;
    int cfg_total   = 0;
    int busy_total  = 0;
    int par_entries = 0;
    int stop1_seen  = 0;
    int prev_state  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("state",   32'(bus.state),   32'(exp_state));
            chk("bit_idx", 32'(bus.bit_idx), 32'(exp_idx));
            chk("busy",    32'(bus.busy),    32'(m_active));
            chk("shift",   32'(bus.shift),   32'((exp_state == 2) && bus.btu));
            chk("done",    32'(bus.done),    32'(m_done));
            chk("cfg_err", 32'(bus.cfg_err), 32'(m_cfg));
            shift_total <= shift_total + (bus.shift ? 1 : 0);
            done_total  <= done_total  + (bus.done ? 1 : 0);
            cfg_total   <= cfg_total   + (bus.cfg_err ? 1 : 0);
            busy_total  <= busy_total  + (bus.busy ? 1 : 0);
            par_entries <= par_entries + ((bus.state == 3'd3 && prev_state != 3) ? 1 : 0);
            stop1_seen  <= stop1_seen  + ((bus.state == 3'd4 && bus.bit_idx == 4'd1) ? 1 : 0);
            prev_state  <= int'(bus.state);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.btu = 1'b1;
            step();
            bus.btu = 1'b0;
            for (int g = 1; g < gap; g++) step();
        end
    endtask

    task automatic go(input int db, input bit par, input bit s2);
        bus.data_bits = 4'(db);
        bus.parity_en = par;
        bus.stop2     = s2;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    int b_shift, b_done, b_cfg, b_busy, b_par, b_stop1;

    task automatic mark();
        step();
        b_shift = shift_total; b_done = done_total; b_cfg = cfg_total;
        b_busy  = busy_total;  b_par  = par_entries; b_stop1 = stop1_seen;
    endtask

    task automatic report(input string tag);
        $display("txn %s: shifts=%0d done=%0d cfg_err=%0d parity=%0d", tag,
                 shift_total - b_shift, done_total - b_done, cfg_total - b_cfg,
                 par_entries - b_par);
    endtask

    initial begin
        bus.start = 1'b0; bus.btu = 1'b0; bus.abort = 1'b0;
        bus.data_bits = 4'd8; bus.parity_en = 1'b0; bus.stop2 = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_idx",   32'(bus.bit_idx), 0);
        chk("rst_done",  32'(bus.done),  0);
        chk("rst_cfg",   32'(bus.cfg_err), 0);
        chk("rst_shift", 32'(bus.shift), 0);
        step(); step();
        rst = 1'b0;
        mark();

        // 8N1, btu every 4 cycles: nothing done after 9 ticks, done after 10.
        go(8, 0, 0);
        chk("8n1_busy_after_start", 32'(bus.busy), 1);
        ticks(9, 4);
        chk("8n1_no_done_at_9", 32'(done_total - b_done), 0);
        ticks(1, 4);
        step();
        chk("8n1_shifts", 32'(shift_total - b_shift), 8);
        chk("8n1_done",   32'(done_total - b_done), 1);
        chk("8n1_parity", 32'(par_entries - b_par), 0);
        report("8N1");
        mark();

        // 7 data, parity, 2 stop with back-to-back ticks: 11 ticks per frame.
        go(7, 1, 1);
        ticks(10, 1);
        chk("7p2_no_done_at_10", 32'(done_total - b_done), 0);
        ticks(1, 1);
        step(); step();
        chk("7p2_shifts",  32'(shift_total - b_shift), 7);
        chk("7p2_parity",  32'(par_entries - b_par), 1);
        chk("7p2_stop1",   32'(stop1_seen - b_stop1), 1);
        chk("7p2_done",    32'(done_total - b_done), 1);
        report("7P2");
        mark();

        // Out-of-range starts: one cfg_err each, never busy.
        go(4, 0, 0);
        go(10, 0, 0);
        step(); step();
        chk("cfg_pulses", 32'(cfg_total - b_cfg), 2);
        chk("cfg_busy",   32'(busy_total - b_busy), 0);
        // start together with abort in IDLE: nothing happens.
        bus.data_bits = 4'd3; bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        step(); step();
        chk("abort_start_cfg",  32'(cfg_total - b_cfg), 2);
        chk("abort_start_busy", 32'(busy_total - b_busy), 0);
        report("cfg");
        mark();

        // Abort together with btu in DATA at bit_idx 3.
        go(8, 0, 0);
        ticks(4, 2);
        chk("abort_pre_idx", 32'(bus.bit_idx), 3);
        bus.btu = 1'b1; bus.abort = 1'b1;
        step();
        bus.btu = 1'b0; bus.abort = 1'b0;
        chk("abort_state", 32'(bus.state), 0);
        chk("abort_idx",   32'(bus.bit_idx), 0);
        ticks(3, 2);
        step();
        chk("abort_shifts", 32'(shift_total - b_shift), 4);
        chk("abort_done",   32'(done_total - b_done), 0);
        report("abort");
        mark();
        go(8, 0, 0);
        ticks(10, 3);
        step();
        chk("post_abort_shifts", 32'(shift_total - b_shift), 8);
        chk("post_abort_done",   32'(done_total - b_done), 1);
        report("post_abort");
        mark();

        // Config changes and start while busy do not disturb the frame.
        go(8, 0, 0);
        ticks(3, 3);
        bus.data_bits = 4'd5; bus.parity_en = 1'b1; bus.stop2 = 1'b1; bus.start = 1'b1;
        ticks(4, 3);
        bus.start = 1'b0;
        ticks(3, 3);
        step();
        chk("midcfg_shifts", 32'(shift_total - b_shift), 8);
        chk("midcfg_done",   32'(done_total - b_done), 1);
        chk("midcfg_parity", 32'(par_entries - b_par), 0);
        report("midcfg");
        bus.parity_en = 1'b0; bus.stop2 = 1'b0;
        mark();

        // Reset during STOP clears everything immediately.
        go(8, 0, 0);
        ticks(9, 4);
        chk("pre_rst_state", 32'(bus.state), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_busy",  32'(bus.busy), 0);
        chk("arst_idx",   32'(bus.bit_idx), 0);
        chk("arst_done",  32'(bus.done), 0);
        step(); step();
        rst = 1'b0;
        mark();
        ticks(3, 3);
        chk("post_rst_idle", 32'(busy_total - b_busy), 0);
        chk("post_rst_done", 32'(done_total - b_done), 0);
        go(6, 0, 1);
        ticks(10, 2);
        step();
        chk("post_rst_shifts", 32'(shift_total - b_shift), 6);
        chk("post_rst_frame",  32'(done_total - b_done), 1);
        report("post_rst");

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
